// File: rtl/pc_branch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_seq_pkg
//  Description : Shared types and constants for the PC / branch sequencer.
//                State encoding of the fetch/execute FSM and the pc_src codes
//                reported for the last committed instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } seq_state_t;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

endpackage : mips_seq_pkg
`default_nettype wire

// File: rtl/pc_branch_sequencer_next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_calc
//  Description : Combinational next-PC selection for one committed instruction.
//                Jump overrides branch; a conditional branch is taken when
//                branch & (alu_zero ^ branch_ne).
//  Ports       : pc, branch, branch_ne, alu_zero, jump, branch_off, jump_idx (in)
//                next_pc, pc_src (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc
    import mips_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic        branch_ne,
    input  logic        alu_zero,
    input  logic        jump,
    input  logic [31:0] branch_off,
    input  logic [25:0] jump_idx,
    output logic [31:0] next_pc,
    output logic [1:0]  pc_src
);

    logic [31:0] w_pc4;
    logic [31:0] w_btgt;
    logic [31:0] w_jtgt;
    logic        w_taken;

    // All arithmetic is modulo 2^32, so pc and targets wrap naturally.
    assign w_pc4   = pc + 32'd4;
    assign w_btgt  = w_pc4 + (branch_off << 2);
    assign w_jtgt  = {w_pc4[31:28], jump_idx, 2'b00};
    // XOR with branch_ne turns beq into bne; alu_zero is don't-care without branch.
    assign w_taken = branch & (alu_zero ^ branch_ne);

    always_comb begin
        next_pc = w_pc4;
        pc_src  = PC_SRC_SEQ;
        if (jump) begin
            next_pc = w_jtgt;
            pc_src  = PC_SRC_JMP;
        end else if (w_taken) begin
            next_pc = w_btgt;
            pc_src  = PC_SRC_BR;
        end
    end

endmodule : next_pc_calc
`default_nettype wire

// File: rtl/pc_branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_branch_sequencer
//  Description : Fetch/execute sequencer for a single-cycle MIPS datapath.
//                Fetches one instruction over an imem req/ack handshake, hands
//                it to the datapath with a one-cycle instr_valid, and on
//                ex_done commits the next PC and updates retire/taken counters.
//  Ports       : clk, rst_n (async active-low), run
//                imem_req/imem_addr/imem_ack/imem_rdata  - instruction fetch
//                instr/instr_valid                       - to decoder
//                ex_done/branch/branch_ne/alu_zero/jump/branch_off/jump_idx
//                pc, pc_src, busy, retire_cnt, taken_cnt - status / debug
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_sequencer
    import mips_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             ex_done,
    input  logic             branch,
    input  logic             branch_ne,
    input  logic             alu_zero,
    input  logic             jump,
    input  logic [31:0]      branch_off,
    input  logic [25:0]      jump_idx,
    output logic [31:0]      pc,
    output logic [1:0]       pc_src,
    output logic             busy,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    seq_state_t       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [1:0]       r_pc_src;
    logic             r_imem_req;
    logic             r_instr_valid;
    logic             r_busy;
    logic [CNT_W-1:0] r_retire_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic [31:0]      w_next_pc;
    logic [1:0]       w_pc_src;

    next_pc_calc u_next_pc_calc (
        .pc         (r_pc),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .alu_zero   (alu_zero),
        .jump       (jump),
        .branch_off (branch_off),
        .jump_idx   (jump_idx),
        .next_pc    (w_next_pc),
        .pc_src     (w_pc_src)
    );

    // Outputs are registered alongside the state so they change exactly on
    // the transition edges; imem_req and busy are set on entry to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_pc_src      <= PC_SRC_SEQ;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_retire_cnt  <= '0;
            r_taken_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_state    <= FETCH;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    // run is deliberately not sampled here; the fetch always completes.
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= EXEC;
                    end
                end
                EXEC: begin
                    r_instr_valid <= 1'b0;
                    if (ex_done) begin
                        r_pc         <= w_next_pc;
                        r_pc_src     <= w_pc_src;
                        r_retire_cnt <= r_retire_cnt + 1'b1;
                        if (w_pc_src != PC_SRC_SEQ) begin
                            r_taken_cnt <= r_taken_cnt + 1'b1;
                        end
                        if (run) begin
                            r_state    <= FETCH;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_src      = r_pc_src;
    assign busy        = r_busy;
    assign retire_cnt  = r_retire_cnt;
    assign taken_cnt   = r_taken_cnt;

endmodule : pc_branch_sequencer
`default_nettype wire

// File: tb/tb_pc_branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_branch_sequencer
//  Description : Directed self-checking bench for pc_branch_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_done = 1'b0;
    logic        branch = 1'b0;
    logic        branch_ne = 1'b0;
    logic        alu_zero = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] branch_off = 32'd0;
    logic [25:0] jump_idx = 26'd0;
    logic [31:0] pc;
    logic [1:0]  pc_src;
    logic        busy;
    logic [31:0] retire_cnt;
    logic [31:0] taken_cnt;

    int checks = 0;
    int failures = 0;
    int exp_ret = 0;
    int exp_tk = 0;

    always #5 clk = ~clk;

    pc_branch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .ex_done     (ex_done),
        .branch      (branch),
        .branch_ne   (branch_ne),
        .alu_zero    (alu_zero),
        .jump        (jump),
        .branch_off  (branch_off),
        .jump_idx    (jump_idx),
        .pc          (pc),
        .pc_src      (pc_src),
        .busy        (busy),
        .retire_cnt  (retire_cnt),
        .taken_cnt   (taken_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a fetch request, acks it, then completes the
    // instruction with the given control inputs on its first EXEC cycle.
    task automatic run_instr(input logic br, input logic bne, input logic z,
                             input logic jmp, input logic [31:0] off,
                             input logic [25:0] idx);
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        if (!imem_req) begin
            checks++;
            failures++;
            $display("FAIL req_timeout got=%b exp=1", imem_req);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack   = 1'b0;
        ex_done    = 1'b1;
        branch     = br;
        branch_ne  = bne;
        alu_zero   = z;
        jump       = jmp;
        branch_off = off;
        jump_idx   = idx;
        tick();
        ex_done = 1'b0;
        branch  = 1'b0; branch_ne = 1'b0; alu_zero = 1'b0; jump = 1'b0;
        branch_off = 32'd0; jump_idx = 26'd0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (imem_req !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL rst_ctrl got=%b%b%b exp=000", imem_req, busy, instr_valid); end
        checks++; if (retire_cnt !== 32'd0 || taken_cnt !== 32'd0 || pc_src !== 2'd0 || instr !== 32'd0) begin
            failures++; $display("FAIL rst_regs got=%h/%h/%h/%h exp=0", retire_cnt, taken_cnt, pc_src, instr); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        run = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || busy !== 1'b1) begin
            failures++; $display("FAIL seq_fetch got=%b/%h/%b exp=1/00000000/1", imem_req, imem_addr, busy); end
        imem_ack = 1'b1; imem_rdata = 32'hA5A5_0001;
        tick();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'hA5A5_0001 || imem_req !== 1'b0) begin
            failures++; $display("FAIL seq_exec got=%b/%h/%b exp=1/a5a50001/0", instr_valid, instr, imem_req); end
        ex_done = 1'b1;
        tick();
        ex_done = 1'b0;
        exp_ret++;
        checks++; if (pc !== 32'h4 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL seq_pc1 got=%h/%b exp=00000004/0", pc, instr_valid); end
        run_instr(0, 0, 0, 0, 32'd0, 26'd0);
        exp_ret++;
        checks++; if (pc !== 32'h8 || pc_src !== 2'd0) begin
            failures++; $display("FAIL seq_pc2 got=%h/%0d exp=00000008/0", pc, pc_src); end
        checks++; if (retire_cnt !== 32'd2 || taken_cnt !== 32'd0) begin
            failures++; $display("FAIL seq_cnt got=%0d/%0d exp=2/0", retire_cnt, taken_cnt); end
    endtask

    task automatic test_branch();
        run_instr(0, 0, 0, 1, 32'd0, 26'h40); exp_ret++; exp_tk++;
        checks++; if (pc !== 32'h100 || pc_src !== 2'd2) begin
            failures++; $display("FAIL jmp_100 got=%h/%0d exp=00000100/2", pc, pc_src); end
        run_instr(1, 0, 1, 0, 32'h3, 26'd0); exp_ret++; exp_tk++;
        checks++; if (pc !== 32'h110 || pc_src !== 2'd1 || taken_cnt !== 32'(exp_tk)) begin
            failures++; $display("FAIL beq_taken got=%h/%0d/%0d exp=00000110/1/%0d", pc, pc_src, taken_cnt, exp_tk); end
        run_instr(0, 0, 0, 1, 32'd0, 26'h40); exp_ret++; exp_tk++;
        run_instr(1, 0, 0, 0, 32'h3, 26'd0); exp_ret++;
        checks++; if (pc !== 32'h104 || pc_src !== 2'd0 || taken_cnt !== 32'(exp_tk)) begin
            failures++; $display("FAIL beq_nt got=%h/%0d/%0d exp=00000104/0/%0d", pc, pc_src, taken_cnt, exp_tk); end
        run_instr(0, 0, 0, 1, 32'd0, 26'h40); exp_ret++; exp_tk++;
        run_instr(1, 1, 0, 0, 32'h3, 26'd0); exp_ret++; exp_tk++;
        checks++; if (pc !== 32'h110 || pc_src !== 2'd1) begin
            failures++; $display("FAIL bne_taken got=%h/%0d exp=00000110/1", pc, pc_src); end
        // branch=0 makes alu_zero irrelevant
        run_instr(0, 1, 0, 0, 32'h3, 26'd0); exp_ret++;
        checks++; if (pc !== 32'h114 || pc_src !== 2'd0) begin
            failures++; $display("FAIL nobr got=%h/%0d exp=00000114/0", pc, pc_src); end
    endtask

    task automatic test_negative_offset();
        run_instr(0, 0, 0, 1, 32'd0, 26'h80); exp_ret++; exp_tk++;
        run_instr(1, 0, 1, 0, 32'hFFFF_FFFE, 26'd0); exp_ret++; exp_tk++;
        checks++; if (pc !== 32'h1FC || pc_src !== 2'd1) begin
            failures++; $display("FAIL neg_off got=%h/%0d exp=000001fc/1", pc, pc_src); end
    endtask

    task automatic test_jump_over_branch();
        run_instr(1, 0, 1, 0, 32'h0FFF_FF84, 26'd0); exp_ret++; exp_tk++;
        checks++; if (pc !== 32'h4000_0010) begin
            failures++; $display("FAIL br_far got=%h exp=40000010", pc); end
        run_instr(1, 0, 1, 1, 32'h3, 26'h40); exp_ret++; exp_tk++;
        checks++; if (pc !== 32'h4000_0100 || pc_src !== 2'd2) begin
            failures++; $display("FAIL jmp_br got=%h/%0d exp=40000100/2", pc, pc_src); end
        checks++; if (retire_cnt !== 32'(exp_ret) || taken_cnt !== 32'(exp_tk)) begin
            failures++; $display("FAIL jmp_br_cnt got=%0d/%0d exp=%0d/%0d", retire_cnt, taken_cnt, exp_ret, exp_tk); end
    endtask

    task automatic test_stall_and_stop();
        int bad;
        bad = 0;
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        // six FETCH cycles; ack only in the last, spurious ex_done before it
        for (int i = 0; i < 6; i++) begin
            if (imem_req !== 1'b1 || imem_addr !== 32'h4000_0100) bad++;
            if (i < 5) begin ex_done = 1'b1; imem_ack = 1'b0; end
            else begin ex_done = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_0005; end
            tick();
        end
        ex_done = 1'b0;
        checks++; if (bad != 0) begin
            failures++; $display("FAIL fetch_stable got=%0d_bad_cycles exp=0", bad); end
        checks++; if (retire_cnt !== 32'(exp_ret) || pc !== 32'h4000_0100 || instr_valid !== 1'b1) begin
            failures++; $display("FAIL spur_exdone got=%0d/%h/%b exp=%0d/40000100/1", retire_cnt, pc, instr_valid, exp_ret); end
        // ack stays high in EXEC (ignored) and run drops
        run = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        checks++; if (instr !== 32'hCAFE_0005 || busy !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL spur_ack got=%h/%b/%b/%b exp=cafe0005/1/0/0", instr, busy, imem_req, instr_valid); end
        imem_ack = 1'b0;
        ex_done = 1'b1;
        tick();
        ex_done = 1'b0;
        exp_ret++;
        tick(); tick();
        checks++; if (pc !== 32'h4000_0104 || busy !== 1'b0 || imem_req !== 1'b0 || retire_cnt !== 32'(exp_ret)) begin
            failures++; $display("FAIL stop_idle got=%h/%b/%b/%0d exp=40000104/0/0/%0d", pc, busy, imem_req, retire_cnt, exp_ret); end
    endtask

    task automatic test_reset_mid_exec();
        run = 1'b1;
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin
            failures++; $display("FAIL pre_rst_exec got=%b exp=1", instr_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0 || retire_cnt !== 32'd0 || taken_cnt !== 32'd0) begin
            failures++; $display("FAIL async_rst_regs got=%h/%0d/%0d exp=0/0/0", pc, retire_cnt, taken_cnt); end
        checks++; if (busy !== 1'b0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'd0 || pc_src !== 2'd0) begin
            failures++; $display("FAIL async_rst_ctrl got=%b/%b/%b/%h/%0d exp=0/0/0/0/0", busy, instr_valid, imem_req, instr, pc_src); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_negative_offset();
        test_jump_over_branch();
        test_stall_and_stop();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_branch_sequencer
`default_nettype wire
